// File: rtl/uart_ctrl.sv
`default_nettype none
// uart_ctrl: shares one uart transmitter among N_REQ requesters (round robin),
// applies baud changes between frames, and buffers RX bytes when UART_CTRL_RX_EN is defined.
module uart_ctrl #(
    parameter int          N_REQ            = 4,
    parameter logic [15:0] BAUD_RESET       = 16'd1302,
    parameter int          TX_START_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_byte,
    output logic [N_REQ-1:0]   req_ack,
    output logic               uart_transmit,
    output logic [7:0]         uart_tx_byte,
    input  logic               uart_is_transmitting,
    input  logic               uart_is_receiving,
    input  logic               uart_received,
    input  logic               uart_recv_error,
    input  logic [7:0]         uart_rx_byte,
    output logic               uart_recv_ack,
    output logic [15:0]        uart_baud,
    input  logic               baud_wr,
    input  logic [15:0]        baud_in,
    output logic               rx_valid,
    output logic [7:0]         rx_data,
    input  logic               rx_ready,
    output logic [7:0]         rx_err_cnt,
    output logic               tx_timeout,
    output logic               tx_busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TX_START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   baud_q, baud_d, shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          rx_quiet;
    logic [PW-1:0] win, idx;
    logic          win_found;

    // First valid requester after the last winner, wrapping modulo N_REQ.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req_valid[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        tx_byte_d     = tx_byte_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        uart_transmit = 1'b0;
        req_ack       = '0;
        case (state_q)
            IDLE: begin
                if (win_found && !uart_is_transmitting && !pending_q) begin
                    state_d   = ISSUE;
                    ptr_d     = win;
                    tx_byte_d = req_byte[{win, 3'b000} +: 8];
                end
            end
            ISSUE: begin
                uart_transmit  = 1'b1;
                req_ack[ptr_q] = 1'b1;
                cnt_d          = '0;
                state_d        = WAIT_START;
            end
            WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TW'(TX_START_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A write in the same cycle as an apply keeps the new value pending.
    always_comb begin
        baud_d    = baud_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (pending_q && state_q == IDLE && !uart_is_transmitting && rx_quiet) begin
            baud_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (baud_wr && baud_in != 16'd0) begin
            shadow_d  = baud_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(N_REQ - 1);
            tx_byte_q <= 8'd0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            baud_q    <= BAUD_RESET;
            shadow_q  <= BAUD_RESET;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tx_byte_q <= tx_byte_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            baud_q    <= baud_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign uart_tx_byte = tx_byte_q;
    assign uart_baud    = baud_q;
    assign tx_timeout   = timeout_q;
    assign tx_busy      = (state_q != IDLE);

`ifdef UART_CTRL_RX_EN
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] err_q, err_d;
    logic       ack_q, ack_d;

    assign rx_quiet = !uart_is_receiving;

    // While the ack is on the wire the core flags are stale, so they are ignored.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        err_d      = err_q;
        ack_d      = 1'b0;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (!ack_q) begin
            if (uart_recv_error) begin
                ack_d = 1'b1;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
            if (uart_received && !rx_valid_q) begin
                rx_valid_d = 1'b1;
                rx_data_d  = uart_rx_byte;
                ack_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            err_q      <= 8'd0;
            ack_q      <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_err_cnt    = err_q;
    assign uart_recv_ack = ack_q;
`else
    logic unused_rx;

    assign rx_quiet      = 1'b1;
    assign unused_rx     = ^{uart_received, uart_recv_error, uart_rx_byte, rx_ready, uart_is_receiving};
    assign rx_valid      = 1'b0;
    assign rx_data       = 8'd0;
    assign rx_err_cnt    = 8'd0;
    assign uart_recv_ack = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// Bench for uart_ctrl: a small behavioural uart core plus a round-robin
// reference derived from the arbitration rules.
module tb_uart_ctrl;
    localparam int N     = 4;
    localparam int FRAME = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_ack;
    logic           uart_transmit;
    logic [7:0]     uart_tx_byte;
    logic           uart_is_transmitting;
    logic           uart_is_receiving;
    logic           uart_received;
    logic           uart_recv_error;
    logic [7:0]     uart_rx_byte;
    logic           uart_recv_ack;
    logic [15:0]    uart_baud;
    logic           baud_wr;
    logic [15:0]    baud_in;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           rx_ready;
    logic [7:0]     rx_err_cnt;
    logic           tx_timeout;
    logic           tx_busy;

    int total = 0;
    int bad   = 0;
    int core_t = -1;
    bit core_auto = 1'b0;
    bit core_never = 1'b0;

    always #5 clk = ~clk;

    uart_ctrl #(.N_REQ(N), .BAUD_RESET(16'd1302), .TX_START_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_byte(req_byte), .req_ack(req_ack),
        .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting), .uart_is_receiving(uart_is_receiving),
        .uart_received(uart_received), .uart_recv_error(uart_recv_error),
        .uart_rx_byte(uart_rx_byte), .uart_recv_ack(uart_recv_ack), .uart_baud(uart_baud),
        .baud_wr(baud_wr), .baud_in(baud_in), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .rx_err_cnt(rx_err_cnt), .tx_timeout(tx_timeout), .tx_busy(tx_busy)
    );

    // Core model: busy starts 2 cycles after the strobe and lasts FRAME cycles.
    task automatic core_step();
        if (core_auto) begin
            if (uart_transmit && !core_never) core_t = 0;
            else if (core_t >= 0) begin
                core_t++;
                if (core_t >= 2 + FRAME) core_t = -1;
            end
            uart_is_transmitting = (core_t >= 2);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        core_step();
    endtask

    task automatic wait_tx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (uart_transmit) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (!tx_busy && !uart_is_transmitting) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        core_t = -1;
        uart_is_transmitting = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        total++;
        if ({uart_transmit, req_ack, uart_tx_byte, uart_recv_ack, rx_valid, rx_data,
             rx_err_cnt, tx_timeout, tx_busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h want 0", {uart_transmit, req_ack, uart_tx_byte,
                     uart_recv_ack, rx_valid, rx_data, rx_err_cnt, tx_timeout, tx_busy});
        end
        total++;
        if (uart_baud !== 16'd1302) begin
            bad++;
            $display("FAIL reset_baud: got %0d want 1302", uart_baud);
        end
    endtask

    task automatic test_startup_busy();
        bit seen, ok;
        rst = 1'b1;
        core_auto = 1'b0;
        uart_is_transmitting = 1'b1;
        tick();
        rst = 1'b0;
        req_byte = {8'h44, 8'h33, 8'h22, 8'h5A};
        req_valid = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (uart_transmit) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL startup_hold: got transmit=1 want 0 while core busy");
        end
        uart_is_transmitting = 1'b0;
        tick();
        total++;
        if (uart_transmit !== 1'b1 || req_ack !== 4'b0001) begin
            bad++;
            $display("FAIL startup_issue: got tx=%0b ack=%b want tx=1 ack=0001", uart_transmit, req_ack);
        end
        total++;
        if (uart_tx_byte !== 8'h5A) begin
            bad++;
            $display("FAIL startup_byte: got %0h want 5a", uart_tx_byte);
        end
        req_valid = '0;
        core_t = 0;
        core_auto = 1'b1;
        wait_idle(200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL startup_idle: got busy want idle");
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b [5];
        int         exp_i [5];
        bit         ok;
        exp_b = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        exp_i = '{0, 1, 2, 3, 0};
        do_reset();
        req_byte = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_tx(200, ok);
            total++;
            if (!ok || uart_tx_byte !== exp_b[n] || req_ack !== 4'(1 << exp_i[n])) begin
                bad++;
                $display("FAIL rr_issue%0d: got byte=%0h ack=%b want byte=%0h ack=%b",
                         n, uart_tx_byte, req_ack, exp_b[n], 4'(1 << exp_i[n]));
            end
        end
        req_valid = '0;
        wait_idle(200, ok);
    endtask

    task automatic test_random_traffic();
        bit [N-1:0]   pend;
        logic [7:0]   b [N];
        logic [7:0]   exp_byte;
        logic [N-1:0] exp_ack;
        int           last, issued, g;
        pend = '0;
        last = 0;
        issued = 0;
        for (int i = 0; i < N; i++) b[i] = 8'h00;
        for (int cyc = 0; cyc < 3000 && issued < 30; cyc++) begin
            tick();
            if (uart_transmit) begin
                g = -1;
                for (int k = 1; k <= N; k++)
                    if (g < 0 && pend[(last + k) % N]) g = (last + k) % N;
                exp_byte = (g < 0) ? 8'h00 : b[g];
                exp_ack  = (g < 0) ? '0 : 4'(1 << g);
                total++;
                if (g < 0 || uart_tx_byte !== exp_byte || req_ack !== exp_ack) begin
                    bad++;
                    $display("FAIL rand_issue%0d: got byte=%0h ack=%b want byte=%0h ack=%b",
                             issued, uart_tx_byte, req_ack, exp_byte, exp_ack);
                end
                if (g >= 0) begin
                    pend[g] = 1'b0;
                    last = g;
                end
                issued++;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b1;
                    b[i] = 8'($urandom);
                end
                req_byte[8*i +: 8] = b[i];
            end
            req_valid = pend;
        end
        total++;
        if (issued < 30) begin
            bad++;
            $display("FAIL rand_count: got %0d issues want 30", issued);
        end
        req_valid = '0;
        wait_idle(200, g[0]);
    endtask

    task automatic test_baud();
        bit ok, early, grant, busy_now;
        int hold;
        req_byte[7:0] = 8'h77;
        req_valid = 4'b0001;
        wait_tx(200, ok);
        req_valid = '0;
        for (int i = 0; i < 10 && !uart_is_transmitting; i++) tick();
        baud_wr = 1'b1;
        baud_in = 16'd651;
`ifdef UART_CTRL_RX_EN
        uart_is_receiving = 1'b1;
`endif
        tick();
        baud_wr = 1'b0;
        req_byte[15:8] = 8'h88;
        req_valid = 4'b0010;
        early = 1'b0;
        grant = 1'b0;
        ok = 1'b0;
        hold = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            busy_now = uart_is_transmitting || uart_is_receiving;
            if (busy_now && uart_baud !== 16'd1302) early = 1'b1;
            if (uart_transmit) begin
                ok = 1'b1;
                if (uart_baud !== 16'd651 || uart_tx_byte !== 8'h88) grant = 1'b1;
            end
            if (!uart_is_transmitting) hold++;
            if (hold == 6) uart_is_receiving = 1'b0;
        end
        req_valid = '0;
        total++;
        if (early) begin
            bad++;
            $display("FAIL baud_early: got new divider while core busy want 1302");
        end
        total++;
        if (!ok || grant) begin
            bad++;
            $display("FAIL baud_grant: got seen=%0b baud=%0d byte=%0h want 651/88", ok, uart_baud, uart_tx_byte);
        end
        wait_idle(200, ok);
        baud_wr = 1'b1;
        baud_in = 16'd0;
        tick();
        baud_wr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (uart_baud !== 16'd651) begin
            bad++;
            $display("FAIL baud_zero: got %0d want 651", uart_baud);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        core_never = 1'b1;
        req_byte[7:0] = 8'h99;
        req_valid = 4'b0001;
        wait_tx(200, ok);
        req_valid = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) begin
                total++;
                if (tx_timeout !== 1'b0 || tx_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_early: got to=%0b busy=%0b want 0/1", tx_timeout, tx_busy);
                end
            end
            if (k == 10) begin
                total++;
                if (tx_timeout !== 1'b1 || tx_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_set: got to=%0b busy=%0b want 1/0", tx_timeout, tx_busy);
                end
            end
        end
        core_never = 1'b0;
        req_valid = 4'b0001;
        wait_tx(200, ok);
        req_valid = '0;
        wait_idle(200, ok);
        total++;
        if (tx_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %0b want 1", tx_timeout);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [N-1:0] acks;
        req_byte[23:16] = 8'h3C;
        req_valid = 4'b0100;
        wait_tx(200, ok);
        req_valid = '0;
        for (int i = 0; i < 10 && !uart_is_transmitting; i++) tick();
        rst = 1'b1;
        #1;
        total++;
        if ({uart_transmit, req_ack, uart_tx_byte, uart_recv_ack, rx_valid, rx_data,
             rx_err_cnt, tx_timeout, tx_busy} !== '0 || uart_baud !== 16'd1302) begin
            bad++;
            $display("FAIL midframe_reset: got busy=%0b to=%0b byte=%0h baud=%0d want 0/0/0/1302",
                     tx_busy, tx_timeout, uart_tx_byte, uart_baud);
        end
        core_t = -1;
        uart_is_transmitting = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        acks = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acks = acks | req_ack;
        end
        total++;
        if (acks !== '0) begin
            bad++;
            $display("FAIL midframe_reack: got %b want 0000", acks);
        end
    endtask

`ifdef UART_CTRL_RX_EN
    task automatic test_rx_basic();
        int acks;
        rx_ready = 1'b0;
        uart_received = 1'b1;
        uart_rx_byte = 8'hA5;
        tick();
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || uart_recv_ack !== 1'b1) begin
            bad++;
            $display("FAIL rx_capture: got v=%0b d=%0h ack=%0b want 1/a5/1", rx_valid, rx_data, uart_recv_ack);
        end
        uart_rx_byte = 8'h3C;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uart_recv_ack) acks++;
        end
        total++;
        if (acks != 0 || rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
            bad++;
            $display("FAIL rx_hold: got acks=%0d d=%0h want 0/a5", acks, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        total++;
        if (rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL rx_drain: got v=%0b want 0", rx_valid);
        end
        tick();
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C || uart_recv_ack !== 1'b1) begin
            bad++;
            $display("FAIL rx_second: got v=%0b d=%0h ack=%0b want 1/3c/1", rx_valid, rx_data, uart_recv_ack);
        end
        uart_received = 1'b0;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_rx_stream();
        logic [7:0] q [$];
        logic [7:0] exp;
        int sent, got;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 2000 && got < 16; cyc++) begin
            tick();
            if (rx_valid && rx_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 8'h00;
                total++;
                if (rx_data !== exp) begin
                    bad++;
                    $display("FAIL rx_stream%0d: got %0h want %0h", got, rx_data, exp);
                end
                got++;
            end
            if (uart_recv_ack) uart_received = 1'b0;
            else if (!uart_received && sent < 16 && $urandom_range(0, 3) == 0) begin
                uart_rx_byte = 8'($urandom);
                uart_received = 1'b1;
                q.push_back(uart_rx_byte);
                sent++;
            end
            rx_ready = ($urandom_range(0, 1) == 1);
        end
        total++;
        if (got != 16) begin
            bad++;
            $display("FAIL rx_stream_count: got %0d want 16", got);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_err_sat();
        bit ok;
        int exp;
        for (int n = 1; n <= 300; n++) begin
            uart_recv_error = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                tick();
                if (uart_recv_ack) ok = 1'b1;
            end
            uart_recv_error = 1'b0;
            exp = (n < 255) ? n : 255;
            if (!ok || n == 1 || n == 100 || n == 255 || n == 300) begin
                total++;
                if (!ok || rx_err_cnt !== 8'(exp)) begin
                    bad++;
                    $display("FAIL err_cnt%0d: got ack=%0b cnt=%0d want 1/%0d", n, ok, rx_err_cnt, exp);
                end
            end
            if (!ok) break;
            tick();
        end
    endtask
`else
    task automatic test_rx_disabled();
        logic [17:0] seen;
        uart_received = 1'b1;
        uart_recv_error = 1'b1;
        uart_rx_byte = 8'hFF;
        rx_ready = 1'b1;
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | {uart_recv_ack, rx_valid, rx_data, rx_err_cnt};
        end
        total++;
        if (seen !== '0) begin
            bad++;
            $display("FAIL rx_tied: got %0h want 0", seen);
        end
        uart_received = 1'b0;
        uart_recv_error = 1'b0;
        uart_is_receiving = 1'b1;
        baud_wr = 1'b1;
        baud_in = 16'd500;
        tick();
        baud_wr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (uart_baud !== 16'd500) begin
            bad++;
            $display("FAIL baud_no_rx_gate: got %0d want 500", uart_baud);
        end
        uart_is_receiving = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_byte = '0;
        uart_is_transmitting = 1'b0;
        uart_is_receiving = 1'b0;
        uart_received = 1'b0;
        uart_recv_error = 1'b0;
        uart_rx_byte = 8'h00;
        baud_wr = 1'b0;
        baud_in = 16'd0;
        rx_ready = 1'b0;
        test_reset();
        test_startup_busy();
        test_round_robin();
        test_random_traffic();
        test_baud();
        test_timeout();
        test_reset_midframe();
`ifdef UART_CTRL_RX_EN
        test_rx_basic();
        test_rx_stream();
        test_err_sat();
`else
        test_rx_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_ctrl.md
# uart_ctrl

Controller that sits in front of the `uart` core and shares its single transmitter among `N_REQ` byte requesters using round-robin arbitration. It owns the core's `baud` input and applies baud changes only between frames. It also buffers received bytes behind a valid/ready interface and generates `recv_ack`. One instance connects directly to one `uart` instance: the `uart_*` ports wire to the same-named core ports, with the prefix dropped.

## Interface
- `N_REQ`, 4: number of transmit requesters (2..8).
- `BAUD_RESET`, 16'd1302: value driven on `uart_baud` after reset.
- `TX_START_TIMEOUT`, 8: cycles allowed for `uart_is_transmitting` to rise after an issue.

Ports:
- `clk`  in  1  master clock.
- `rst`  in  1  asynchronous, active-high reset; also drives the core's `rst`.
- `req_valid`  in  N_REQ  requester i has a byte pending; hold until `req_ack[i]`.
- `req_byte`  in  8*N_REQ  byte of requester i at bits [8i+7:8i]; stable while valid.
- `req_ack`  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- `uart_transmit`  out  1  one-cycle transmit strobe to the core.
- `uart_tx_byte`  out  8  byte to the core; registered.
- `uart_is_transmitting`  in  1  core TX busy.
- `uart_is_receiving`  in  1  core RX busy.
- `uart_received`  in  1  core byte-ready flag (held until ack).
- `uart_recv_error`  in  1  core framing-error flag (held until ack).
- `uart_rx_byte`  in  8  core received byte.
- `uart_recv_ack`  out  1  one-cycle clear pulse to the core.
- `uart_baud`  out  16  divider value to the core.
- `baud_wr`  in  1  load `baud_in` as the pending divider.
- `baud_in`  in  16  new divider; 0 is ignored.
- `rx_valid`  out  1  `rx_data` holds an unread byte.
- `rx_data`  out  8  buffered received byte.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `rx_err_cnt`  out  8  saturating count of framing errors.
- `tx_timeout`  out  1  sticky; core never started a frame after an issue. Cleared by reset only.
- `tx_busy`  out  1  TX FSM is not in IDLE.

## Operation
- Reset values:
  - All outputs 0, except `uart_baud`=`BAUD_RESET`.
  - Grant pointer = `N_REQ-1`, so requester 0 wins first.
  - `baud_pending`=0.
- TX FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
  - IDLE → ISSUE when `|req_valid`, `!uart_is_transmitting` and `!baud_pending`.
    - The winner g is the first valid requester searching from pointer+1, modulo `N_REQ`.
    - On this transition: latch `uart_tx_byte`=`req_byte[g]` and set pointer=g.
  - ISSUE: `uart_transmit`=1 and `req_ack[g]`=1 for exactly this cycle; then → WAIT_START.
  - WAIT_START: → WAIT_DONE on `uart_is_transmitting`=1.
    - After `TX_START_TIMEOUT` cycles without it: set `tx_timeout` and → IDLE.
  - WAIT_DONE: → IDLE on `uart_is_transmitting`=0.
- After reset the core reports busy during its restart delay. IDLE must not issue until `uart_is_transmitting` falls.
- Baud update:
  - `baud_wr` with nonzero `baud_in` loads a shadow register and sets `baud_pending`. A later write overwrites the shadow.
  - Apply when the TX FSM is in IDLE, `!uart_is_transmitting` and `!uart_is_receiving`: `uart_baud`←shadow and clear `baud_pending`.
  - While pending, no new grant is made; a frame in flight completes.
- RX path:
  - When `uart_received`=1 and `rx_valid`=0:
    - capture `rx_data`←`uart_rx_byte` and set `rx_valid`;
    - pulse `uart_recv_ack` for 1 cycle.
  - When `uart_recv_error`=1: increment `rx_err_cnt`, saturating at 255, and pulse `uart_recv_ack`.
    - If `uart_received` is also high and `rx_valid`=0, capture in the same cycle.
  - In the cycle after an ack pulse, ignore `uart_received` and `uart_recv_error`. The core's flags are still high then, and this blanking prevents a double capture.
  - If `rx_valid`=1, `uart_received` is left unacked; the core holds its flag. A byte overwritten inside the core is lost silently.
  - `rx_valid` clears in the cycle after `rx_valid && rx_ready`. A new capture is possible from the following cycle.

## Timing
- Latency from `req_valid` to `uart_transmit`: 1 cycle.
  - `req_valid` seen in IDLE at cycle t gives `uart_transmit` and `req_ack` at t+1.
- Minimum gap between issues: bounded by the core, about (10 bit periods + restart delay) × 4 × baud.
- Latency from `uart_received` to `rx_valid` and `uart_recv_ack`: 1 cycle.
- Simultaneous `baud_wr` and a grant-eligible IDLE: the grant wins, and the baud change waits for the next idle gap.
- Reset mid-frame: `rst` returns every output to its reset value immediately. The in-flight requester receives no second ack.

## Configuration
- `UART_CTRL_RX_EN` defined: RX path, `rx_*` outputs and `uart_recv_ack` generation are present.
- Undefined:
  - `uart_recv_ack`, `rx_valid`, `rx_data` and `rx_err_cnt` are tied to 0, and `rx_ready` is ignored.
  - Baud apply no longer checks `uart_is_receiving`.

## Test plan
- After reset, `uart_is_transmitting` stays 1 for 20 cycles while `req_valid`=4'b0001 → no `uart_transmit` until it falls; then `uart_transmit` and `req_ack`=4'b0001 one cycle later, with `uart_tx_byte`=`req_byte[7:0]`.
- `req_valid`=4'b1111 held throughout, bytes 0x10/0x21/0x32/0x43 → issue order 0x10, 0x21, 0x32, 0x43, then 0x10 again.
- `baud_wr`=1, `baud_in`=651 mid-frame → `uart_baud` stays 1302 until `uart_is_transmitting`=0 and `uart_is_receiving`=0, then reads 651; no grant while pending.
- Core forced so `uart_is_transmitting` never rises after an issue → `tx_timeout`=1 after 8 cycles, FSM back in IDLE.
- `uart_received`=1 with `uart_rx_byte`=0xA5 and `rx_ready`=0 → `rx_valid`=1, `rx_data`=0xA5, one ack pulse. A second byte held by the core gets no ack until `rx_ready`=1 and the buffer drains.
- 300 cycles of `uart_recv_error` pulses, each released after its ack → `rx_err_cnt` saturates at 255.
